spi_slave_regs: RTL and testbench

Parametrised, single-clock SPI slave for the ADC model's control port, replacing the split sclk/sys_clk design with oversampled SPI inputs so all logic runs on `sys_clk`. It decodes the 16-bit ADC instruction word (R/W, W1:W0 byte count, address). It supports 1/2/3-byte and streaming transfers, MSB- or LSB-first ordering, and 3-wire or 4-wire pin modes. It drives a simple register-bank bus (write strobe, read strobe with 1-cycle read data) that the register file and clock divider hang off.

---
 rtl/spi_slave_regs.sv | 212 +++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// SPI slave for the ADC control port: oversamples sclk/ss_n/sdi on sys_clk, decodes the
// 16-bit instruction word and drives a register-bank bus with write/read strobes.
module spi_slave_regs #(
    parameter int unsigned ADDR_W     = 13,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter bit          THREE_WIRE = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {S_IDLE, S_INSTR, S_WDATA, S_RDATA, S_DONE} state_t;

    state_t state_q, state_d;

    logic [2:0]        sclk_q, ss_q;
    logic [1:0]        sdi_q;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [15:0]       rx_q, rx_d, rx_next;
    logic [7:0]        tx_q, tx_d, tx_src, wbyte;
    logic [2:0]        rdbit_q, rdbit_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_step;
    logic [1:0]        bytes_q, bytes_d;
    logic              stream_q, stream_d;
    logic              last_q, last_d;
    logic              rd_pend_q, rd_pend_d;
    logic              sdo_q, sdo_d, oe_q, oe_d;
    logic              wr_q, wr_d, rd_q, rd_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              rise, fall, ss_fall, ss_hi, din;

    assign rise    = sclk_q[1] & ~sclk_q[2];
    assign fall    = ~sclk_q[1] & sclk_q[2];
    assign ss_fall = ~ss_q[1] & ss_q[2];
    assign ss_hi   = ss_q[1];
    assign din     = sdi_q[1];

    assign rx_next   = LSB_FIRST ? {din, rx_q[15:1]} : {rx_q[14:0], din};
    assign wbyte     = LSB_FIRST ? rx_next[15:8] : rx_next[7:0];
    assign tx_src    = rd_pend_q ? reg_rdata : tx_q;
    assign addr_step = LSB_FIRST ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        rx_d      = rx_q;
        tx_d      = rd_pend_q ? reg_rdata : tx_q;
        rdbit_d   = rdbit_q;
        addr_d    = addr_q;
        bytes_d   = bytes_q;
        stream_d  = stream_q;
        last_d    = last_q;
        rd_pend_d = rd_q;
        sdo_d     = sdo_q;
        oe_d      = 1'b0;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        raddr_d   = raddr_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (ss_fall) begin
                    state_d  = S_INSTR;
                    bitcnt_d = '0;
                end
            end
            S_INSTR: begin
                if (rise) begin
                    rx_d     = rx_next;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd15) begin
                        addr_d   = rx_next[ADDR_W-1:0];
                        bytes_d  = rx_next[14:13];
                        stream_d = &rx_next[14:13];
                        if (rx_next[15]) begin
                            state_d = S_RDATA;
                            rd_d    = 1'b1;
                            raddr_d = rx_next[ADDR_W-1:0];
                            rdbit_d = '0;
                            last_d  = 1'b0;
                            oe_d    = 1'b1;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (rise) begin
                    rx_d     = rx_next;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) begin
                        wr_d     = 1'b1;
                        wdata_d  = wbyte;
                        raddr_d  = addr_q;
                        addr_d   = addr_step;
                        bitcnt_d = '0;
                        if (!stream_q) begin
                            if (bytes_q == 2'd0) state_d = S_DONE;
                            else                 bytes_d = bytes_q - 2'd1;
                        end
                    end
                end
            end
            S_RDATA: begin
                oe_d = 1'b1;
                if (fall && !last_q) begin
                    // tx_src bypasses a reload landing in the same cycle as the fall
                    sdo_d   = LSB_FIRST ? tx_src[0] : tx_src[7];
                    tx_d    = LSB_FIRST ? {1'b0, tx_src[7:1]} : {tx_src[6:0], 1'b0};
                    rdbit_d = rdbit_q + 3'd1;
                    if (rdbit_q == 3'd7) begin
                        addr_d = addr_step;
                        if (stream_q || bytes_q != 2'd0) begin
                            rd_d    = 1'b1;
                            raddr_d = addr_step;
                            if (!stream_q) bytes_d = bytes_q - 2'd1;
                        end else begin
                            last_d = 1'b1;
                        end
                    end
                end else if (rise && last_q) begin
                    // Keep driving the final bit until the master has sampled it.
                    state_d = S_DONE;
                    oe_d    = 1'b0;
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && ss_hi) begin
            state_d  = S_IDLE;
            oe_d     = 1'b0;
            rd_d     = 1'b0;
            bitcnt_d = '0;
        end

        if (THREE_WIRE && !oe_d) sdo_d = 1'b0;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            // ss_n chain clears low so a select held through reset never looks like a new fall
            sclk_q    <= '0;
            ss_q      <= '0;
            sdi_q     <= '0;
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            rdbit_q   <= '0;
            addr_q    <= '0;
            bytes_q   <= '0;
            stream_q  <= 1'b0;
            last_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            sdo_q     <= 1'b0;
            oe_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            raddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[1:0], sclk};
            ss_q      <= {ss_q[1:0], ss_n};
            sdi_q     <= {sdi_q[0], sdi};
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            rdbit_q   <= rdbit_d;
            addr_q    <= addr_d;
            bytes_q   <= bytes_d;
            stream_q  <= stream_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            sdo_q     <= sdo_d;
            oe_q      <= oe_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            raddr_q   <= raddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
        end
    end

    assign sdo       = sdo_q;
    assign sdo_oe    = oe_q;
    assign reg_wr_en = wr_q;
    assign reg_rd_en = rd_q;
    assign reg_addr  = raddr_q;
    assign reg_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench: an MSB-first 3-wire slave and an LSB-first 4-wire slave share sclk/sdi.
module tb_spi_slave_regs;

    localparam int unsigned H = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sclk, sdi, ss_n_m, ss_n_l;
    logic        sdo_m, oe_m, wr_m, rd_m, busy_m;
    logic [12:0] addr_m;
    logic [7:0]  wdata_m, rdata_m;
    logic        sdo_l, oe_l, wr_l, rd_l, busy_l;
    logic [12:0] addr_l;
    logic [7:0]  wdata_l, rdata_l;

    assign rdata_l = 8'h00;

    spi_slave_regs #(.ADDR_W(13), .LSB_FIRST(1'b0), .THREE_WIRE(1'b1)) dut_m (
        .sys_clk(clk), .sys_reset(rst), .sclk(sclk), .ss_n(ss_n_m), .sdi(sdi),
        .sdo(sdo_m), .sdo_oe(oe_m), .reg_wr_en(wr_m), .reg_rd_en(rd_m),
        .reg_addr(addr_m), .reg_wdata(wdata_m), .reg_rdata(rdata_m), .busy(busy_m)
    );

    spi_slave_regs #(.ADDR_W(13), .LSB_FIRST(1'b1), .THREE_WIRE(1'b0)) dut_l (
        .sys_clk(clk), .sys_reset(rst), .sclk(sclk), .ss_n(ss_n_l), .sdi(sdi),
        .sdo(sdo_l), .sdo_oe(oe_l), .reg_wr_en(wr_l), .reg_rd_en(rd_l),
        .reg_addr(addr_l), .reg_wdata(wdata_l), .reg_rdata(rdata_l), .busy(busy_l)
    );

    // Register bank: read data registered one cycle after the strobe.
    always @(posedge clk) begin
        if (rst)       rdata_m <= 8'h00;
        else if (rd_m) rdata_m <= (addr_m == 13'h001) ? 8'h5A :
                                  (addr_m == 13'h000) ? 8'hC3 : 8'hEE;
    end

    logic [12:0] wa_m[$], ra_m[$], wa_l[$];
    logic [7:0]  wd_m[$], wd_l[$];

    always @(negedge clk) begin
        if (wr_m) begin wa_m.push_back(addr_m); wd_m.push_back(wdata_m); end
        if (rd_m) ra_m.push_back(addr_m);
        if (wr_l) begin wa_l.push_back(addr_l); wd_l.push_back(wdata_l); end
    end

    int unsigned n_chk = 0, n_pass = 0, n_fail = 0;
    logic        smp_sdo, smp_oe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sbit(input logic b);
        sdi = b;
        cyc(H);
        sclk    = 1'b1;
        smp_sdo = sdo_m;
        smp_oe  = oe_m;
        cyc(H);
        sclk = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input int n, input bit lsb);
        for (int k = 0; k < n; k++) sbit(lsb ? w[k] : w[n-1-k]);
    endtask

    task automatic tx_start(input bit l);
        if (l) ss_n_l = 1'b0;
        else   ss_n_m = 1'b0;
        cyc(4);
    endtask

    task automatic tx_end();
        cyc(H);
        ss_n_m = 1'b1;
        ss_n_l = 1'b1;
        cyc(10);
    endtask

    task automatic clear_q();
        wa_m.delete(); wd_m.delete(); ra_m.delete(); wa_l.delete(); wd_l.delete();
    endtask

    task automatic chk_reset_outs(input string pfx);
        chk({pfx, "_sdo"},    sdo_m,   0);
        chk({pfx, "_oe"},     oe_m,    0);
        chk({pfx, "_wr"},     wr_m,    0);
        chk({pfx, "_rd"},     rd_m,    0);
        chk({pfx, "_addr"},   addr_m,  0);
        chk({pfx, "_wdata"},  wdata_m, 0);
        chk({pfx, "_busy"},   busy_m,  0);
    endtask

    logic [15:0] word;
    logic        oe_acc, oe_all;
    int          nw, nr;

    initial begin
        rst = 1'b1; sclk = 1'b0; sdi = 1'b0; ss_n_m = 1'b1; ss_n_l = 1'b1;
        cyc(3);
        chk_reset_outs("reset");
        rst = 1'b0;
        cyc(5);

        // Single-byte write, then extra clocks in DONE must not strobe.
        clear_q();
        tx_start(0);
        chk("wr1_busy", busy_m, 1);
        send(16'h0018, 16, 0);
        send(16'h00A5, 8, 0);
        send(16'h00FF, 8, 0);
        tx_end();
        chk("wr1_count", wa_m.size(), 1);
        chk("wr1_addr", wa_m[0], 13'h018);
        chk("wr1_data", wd_m[0], 8'hA5);
        chk("wr1_rdcount", ra_m.size(), 0);
        chk("wr1_busy_end", busy_m, 0);

        // Streaming write, MSB-first: address decrements.
        clear_q();
        tx_start(0);
        send(16'h6010, 16, 0);
        send(16'h0011, 8, 0); send(16'h0022, 8, 0); send(16'h0033, 8, 0);
        tx_end();
        chk("strm_m_count", wa_m.size(), 3);
        chk("strm_m_a0", wa_m[0], 13'h010); chk("strm_m_d0", wd_m[0], 8'h11);
        chk("strm_m_a1", wa_m[1], 13'h00F); chk("strm_m_d1", wd_m[1], 8'h22);
        chk("strm_m_a2", wa_m[2], 13'h00E); chk("strm_m_d2", wd_m[2], 8'h33);

        // Streaming write, LSB-first: address increments.
        clear_q();
        tx_start(1);
        send(16'h6010, 16, 1);
        send(16'h0011, 8, 1); send(16'h0022, 8, 1); send(16'h0033, 8, 1);
        tx_end();
        chk("strm_l_count", wa_l.size(), 3);
        chk("strm_l_a0", wa_l[0], 13'h010); chk("strm_l_d0", wd_l[0], 8'h11);
        chk("strm_l_a1", wa_l[1], 13'h011); chk("strm_l_d1", wd_l[1], 8'h22);
        chk("strm_l_a2", wa_l[2], 13'h012); chk("strm_l_d2", wd_l[2], 8'h33);
        chk("strm_m_idle", wa_m.size(), 0);

        // Two-byte read.
        clear_q();
        tx_start(0);
        oe_acc = 1'b0;
        for (int k = 15; k >= 0; k--) begin
            word = 16'hA001;
            sbit(word[k]);
            oe_acc |= smp_oe;
        end
        chk("rd_instr_oe", oe_acc, 0);
        word   = '0;
        oe_all = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sbit(1'b0);
            word   = {word[14:0], smp_sdo};
            oe_all &= smp_oe;
        end
        chk("rd_sdo", word, 16'h5AC3);
        chk("rd_oe_data", oe_all, 1);
        sbit(1'b0);
        chk("rd_oe_after", smp_oe, 0);
        tx_end();
        chk("rd_count", ra_m.size(), 2);
        chk("rd_addr0", ra_m[0], 13'h001);
        chk("rd_addr1", ra_m[1], 13'h000);
        chk("rd_wrcount", wa_m.size(), 0);

        // Address wrap on decrement from 0.
        clear_q();
        tx_start(0);
        send(16'h2000, 16, 0);
        send(16'h003C, 8, 0); send(16'h007E, 8, 0);
        tx_end();
        chk("wrap_count", wa_m.size(), 2);
        chk("wrap_a0", wa_m[0], 13'h0000); chk("wrap_d0", wd_m[0], 8'h3C);
        chk("wrap_a1", wa_m[1], 13'h1FFF); chk("wrap_d1", wd_m[1], 8'h7E);

        // Abort after 5 data bits, then a clean write.
        clear_q();
        tx_start(0);
        send(16'h0020, 16, 0);
        send(16'h0016, 5, 0);
        ss_n_m = 1'b1;
        cyc(4);
        chk("abort_busy", busy_m, 0);
        chk("abort_oe", oe_m, 0);
        cyc(10);
        chk("abort_wrcount", wa_m.size(), 0);
        tx_start(0);
        send(16'h0021, 16, 0);
        send(16'h0096, 8, 0);
        tx_end();
        chk("post_abort_count", wa_m.size(), 1);
        chk("post_abort_addr", wa_m[0], 13'h021);
        chk("post_abort_data", wd_m[0], 8'h96);

        // Reset during the read data phase with ss_n held low.
        clear_q();
        tx_start(0);
        send(16'hA001, 16, 0);
        send(16'h0005, 3, 0);
        chk("rst_rd_before", ra_m.size(), 1);
        rst = 1'b1;
        cyc(1);
        chk_reset_outs("midrst");
        rst = 1'b0;
        nw = wa_m.size();
        nr = ra_m.size();
        send(16'h03FF, 10, 0);
        chk("midrst_busy", busy_m, 0);
        chk("midrst_no_wr", wa_m.size(), nw);
        chk("midrst_no_rd", ra_m.size(), nr);
        tx_end();
        tx_start(0);
        send(16'h0005, 16, 0);
        send(16'h0081, 8, 0);
        tx_end();
        chk("recover_count", wa_m.size(), 1);
        chk("recover_addr", wa_m[0], 13'h005);
        chk("recover_data", wd_m[0], 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
